// File: rtl/lcd_angle_display.sv
// lcd_angle_display
// Samples a quadrature-encoder angle at the refresh rate and writes it to an
// HD44780-style character LCD. The display shows three digits followed by a
// degree sign, or "ERR" when the angle is out of range. A power-up wait and
// the LCD init sequence run once after every reset.
//
// Ports
//   clk         system clock, single domain
//   reset       synchronous, active-high
//   angle       raw encoder count, sampled only when a redraw starts
//   data        LCD DB[7:0]
//   rs          0 = command byte, 1 = character byte
//   rw          always 0 (write-only bus)
//   e           LCD enable strobe
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse once the last byte of a redraw has finished
//
// state    | meaning
// PWR_WAIT | power-up delay before the first init byte
// INIT     | sending 0x38, 0x0C, 0x06, 0x01
// IDLE     | waiting for a refresh tick
// SNAP     | latch the angle input
// CONV1    | degrees = a*360 / COUNTS_PER_REV, keep the remainder
// CONV2    | round, wrap 360 to 0, build the three characters
// SET_ADDR | send the DDRAM address command
// WR_CHAR  | send three characters and the degree sign
module lcd_angle_display #(
  parameter int          CLK_HZ         = 50000000,
  parameter int          REFRESH_HZ     = 60,
  parameter int          ANGLE_W        = 12,
  parameter int          COUNTS_PER_REV = 1006,
  parameter logic [6:0]  DISP_ADDR      = 7'h00,
  parameter int          LEADING_ZEROS  = 1,
  parameter int          E_PULSE_CYC    = 25,
  parameter int          CMD_WAIT_CYC   = 2500,
  parameter int          CLEAR_WAIT_CYC = 100000,
  parameter int          POWERUP_CYC    = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ANGLE_W-1:0] angle,
  output logic [7:0]         data,
  output logic               rs,
  output logic               rw,
  output logic               e,
  output logic               busy,
  output logic               frame_done
);

  localparam int TICK_DIV = CLK_HZ / REFRESH_HZ;
  localparam int REF_W    = $clog2(TICK_DIV + 1);
  localparam int M1       = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int M2       = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int CNT_MAX  = (M1 > M2) ? M1 : M2;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  // a*360 needs 9 bits beyond the encoder width
  localparam int PROD_W   = ANGLE_W + 9;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, SNAP, CONV1, CONV2, SET_ADDR, WR_CHAR
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [7:0]          data_q, data_d;
  logic                rs_q, rs_d;
  logic                e_q, e_d;
  logic                fd_q, fd_d;
  logic [ANGLE_W-1:0]  angle_q, angle_d;
  logic [PROD_W-1:0]   deg_q, deg_d;
  logic [PROD_W-1:0]   rem_q, rem_d;
  logic                err_q, err_d;
  logic [2:0][7:0]     chars_q, chars_d;

  logic                tick;
  logic                xfer_done;
  logic [CNT_W-1:0]    wait_lim;
  logic [PROD_W-1:0]   prod, deg_div, deg_rnd;
  logic [8:0]          deg9;
  logic [7:0]          hund, tens, units;
  logic [2:0][7:0]     chars_new;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] char_sel(input logic [1:0] i, input logic [2:0][7:0] c);
    case (i)
      2'd0:    return c[0];
      2'd1:    return c[1];
      2'd2:    return c[2];
      default: return 8'hDF;
    endcase
  endfunction

  // angle-to-character datapath
  always_comb begin
    prod     = PROD_W'(angle_q) * PROD_W'(360);
    deg_div  = prod / PROD_W'(COUNTS_PER_REV);
    deg_rnd  = deg_q + PROD_W'(rem_q > PROD_W'(COUNTS_PER_REV / 2));
    deg9     = (deg_rnd == PROD_W'(360)) ? 9'd0 : 9'(deg_rnd);
    hund     = 8'(deg9 / 9'd100);
    tens     = 8'((deg9 / 9'd10) % 9'd10);
    units    = 8'(deg9 % 9'd10);
    chars_new[0] = 8'h30 + hund;
    chars_new[1] = 8'h30 + tens;
    chars_new[2] = 8'h30 + units;
    if (LEADING_ZEROS == 0 && hund == 8'd0) begin
      chars_new[0] = 8'h20;
      if (tens == 8'd0) chars_new[1] = 8'h20;
    end
    if (err_q) chars_new = {8'h52, 8'h52, 8'h45};
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    rs_d      = rs_q;
    fd_d      = 1'b0;
    angle_d   = angle_q;
    deg_d     = deg_q;
    rem_d     = rem_q;
    err_d     = err_q;
    chars_d   = chars_q;
    xfer_done = 1'b0;

    tick  = (ref_q == REF_W'(TICK_DIV - 1));
    ref_d = tick ? '0 : ref_q + REF_W'(1);

    // the clear command needs the long settle time
    wait_lim = (!rs_q && data_q == 8'h01) ? CNT_W'(CLEAR_WAIT_CYC - 1)
                                          : CNT_W'(CMD_WAIT_CYC - 1);

    if (state_q inside {INIT, SET_ADDR, WR_CHAR}) begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_PULSE;
          cnt_d   = '0;
        end
        PH_PULSE: begin
          if (cnt_q == CNT_W'(E_PULSE_CYC - 1)) begin
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == wait_lim) begin
            xfer_done = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
          state_d = INIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = 2'd0;
          data_d  = init_byte(2'd0);
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      INIT: begin
        if (xfer_done) begin
          phase_d = PH_SETUP;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = init_byte(idx_q + 2'd1);
          end
        end
      end
      IDLE: begin
        if (tick) state_d = SNAP;
      end
      SNAP: begin
        angle_d = angle;
        state_d = CONV1;
      end
      CONV1: begin
        deg_d   = deg_div;
        rem_d   = prod - deg_div * PROD_W'(COUNTS_PER_REV);
        err_d   = PROD_W'(angle_q) >= PROD_W'(COUNTS_PER_REV);
        state_d = CONV2;
      end
      CONV2: begin
        chars_d = chars_new;
        state_d = SET_ADDR;
        phase_d = PH_SETUP;
        cnt_d   = '0;
        data_d  = {1'b1, DISP_ADDR};
        rs_d    = 1'b0;
      end
      SET_ADDR: begin
        if (xfer_done) begin
          state_d = WR_CHAR;
          phase_d = PH_SETUP;
          idx_d   = 2'd0;
          data_d  = chars_q[0];
          rs_d    = 1'b1;
        end
      end
      WR_CHAR: begin
        if (xfer_done) begin
          phase_d = PH_SETUP;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            fd_d    = 1'b1;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = char_sel(idx_q + 2'd1, chars_q);
          end
        end
      end
      default: ;
    endcase

    e_d = (phase_d == PH_PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PWR_WAIT;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      ref_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      fd_q    <= 1'b0;
      angle_q <= '0;
      deg_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      chars_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ref_q   <= ref_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      fd_q    <= fd_d;
      angle_q <= angle_d;
      deg_q   <= deg_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      chars_q <= chars_d;
    end
  end

  assign data       = data_q;
  assign rs         = rs_q;
  assign rw         = 1'b0;
  assign e          = e_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = fd_q;

endmodule

// File: doc/lcd_angle_display.md
LCD_ANGLE_DISPLAY -- requirements
Module: lcd_angle_display

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CLK_HZ, 50000000, system clock frequency.
  REFRESH_HZ, 60, angle sample/redraw rate.
  ANGLE_W, 12, encoder count width.
  COUNTS_PER_REV, 1006, encoder counts per 360 degrees.
  DISP_ADDR, 7'h00, DDRAM address of the first character.
  LEADING_ZEROS, 1, 1 = "007"; 0 = blank leading zeros to 0x20 ("  7").
  E_PULSE_CYC, 25, E high time in clocks.
  CMD_WAIT_CYC, 2500, post-byte wait in clocks.
  CLEAR_WAIT_CYC, 100000, post-clear (0x01) wait in clocks.
  POWERUP_CYC, 2000000, wait after reset before the first init byte.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  system clock; single clock domain.
  reset  in  1  synchronous, active-high reset.
  angle  in  ANGLE_W  raw encoder angle, sampled only at refresh.
  data  out  8  LCD DB[7:0].
  rs  out  1  0 = command, 1 = character.
  rw  out  1  LCD R/W; tied 0 (write only).
  e  out  1  LCD enable strobe.
  busy  out  1  high when the FSM is in any state except IDLE.
  frame_done  out  1  one-cycle pulse after the last byte of a redraw completes.

Function
REQ-003 The refresh counter SHALL count 0..CLK_HZ/REFRESH_HZ-1 continuously and assert an internal tick on the wrap cycle.
REQ-004 The FSM states SHALL be PWR_WAIT, INIT, IDLE, SNAP, CONV1, CONV2, SET_ADDR, WR_CHAR.
REQ-005 PWR_WAIT SHALL hold for POWERUP_CYC clocks, then go to INIT.
REQ-006 INIT SHALL send the commands 0x38, 0x0C, 0x06, 0x01 in order, then go to IDLE.
REQ-007 Each byte transfer SHALL follow this cycle sequence:
  - 1 cycle: data and rs set up, e=0.
  - E_PULSE_CYC cycles: e=1.
  - Then e=0 and a wait of CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC after 0x01.
  - data and rs SHALL stay stable from setup until the wait ends.
REQ-008 In IDLE, a tick SHALL go to SNAP, which latches angle in one cycle.
REQ-009 A tick while busy SHALL be dropped (no queueing); the next tick is sampled normally.
REQ-010 CONV1 SHALL register deg = floor(a*360/COUNTS_PER_REV) and rem = a*360 - deg*COUNTS_PER_REV.
REQ-011 deg SHALL round up when rem > COUNTS_PER_REV/2 (integer division); a tie SHALL round down.
REQ-012 A rounded result of 360 SHALL wrap to 0.
REQ-013 Intermediate products SHALL be at least ANGLE_W+9 bits wide; no truncation is permitted.
REQ-014 CONV2 SHALL register three ASCII digits (0x30 + BCD digit), hundreds first.
REQ-015 When LEADING_ZEROS=0, a zero hundreds digit SHALL be 0x20, and a zero tens digit SHALL be 0x20 when hundreds is also zero; the units digit is always numeric.
REQ-016 A latched angle >= COUNTS_PER_REV SHALL display the characters "ERR" instead of digits.
REQ-017 SET_ADDR SHALL send command 0x80|DISP_ADDR (rs=0).
REQ-018 WR_CHAR SHALL send 4 characters (rs=1): the 3 digit or "ERR" characters, then 0xDF (degree sign).
REQ-019 After the last character's wait, the FSM SHALL pulse frame_done for 1 cycle and return to IDLE.
REQ-020 rw SHALL be 0 in every cycle.

Reset
REQ-021 While reset=1, every register SHALL clear on the clock edge: state=PWR_WAIT, counters=0, data=8'h00, rs=0, e=0, frame_done=0; busy=1.
REQ-022 Reset asserted mid-transfer (including with e=1) SHALL drop e to 0 on the next edge; the full init sequence SHALL repeat after reset release.

Verification (scaled parameters: CLK_HZ=1000, REFRESH_HZ=10, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8, POWERUP_CYC=10)
REQ-023 Reset release -> 10 idle cycles, then bytes 38,0C,06,01 (rs=0), each with e high exactly 2 cycles; busy falls after the 8-cycle clear wait.
REQ-024 angle=503 at tick -> bytes 80(rs=0), 31,38,30,DF(rs=1) = "180°"; then one frame_done pulse.
REQ-025 angle=1005 -> "000°" (360 wraps); angle=2 -> "001°"; angle=1 -> "000°".
REQ-026 LEADING_ZEROS=0, angle=3 -> 20,20,31,DF; angle=1006 -> 45,52,52,DF ("ERR°").
REQ-027 angle changed every clock during a redraw -> displayed digits match only the value latched in SNAP; a tick during the redraw is dropped.
REQ-028 reset pulsed while e=1 in WR_CHAR -> e=0 next cycle; data=00; the PWR_WAIT/INIT sequence replays in full.
